slice_passthru: RTL and testbench



---
 rtl/slice_pkg.sv | 13 +
 rtl/nib_slice.sv | 20 ++
 rtl/slice_passthru.sv | 50 +++++
 tb/tb_slice_passthru.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/slice_pkg.sv
// Shared types for the slice pass-through block: nibble width and the
// descending/ascending 4-bit views used to exercise range conversion.
package slice_pkg;

    localparam int NIB_W = 4;

    // Natural descending nibble, bit 3 is the MSB.
    typedef logic [NIB_W-1:0] nibble_t;

    // Ascending nibble, bit 0 is the MSB (leftmost).
    typedef logic [0:NIB_W-1] nibble_asc_t;

endpackage : slice_pkg

// File: rtl/nib_slice.sv
// One 4-bit slice: copies a descending nibble into an ascending
// intermediate and back again. Whole-vector assignments map left bit to left
// bit, so the MSB stays the MSB and the net effect is identity. Plain
// continuous assigns keep X/Z untouched.
module nib_slice
    import slice_pkg::*;
(
    input  nibble_t i_nib,
    output nibble_t o_nib
);

    nibble_asc_t w_asc;

    // Descending [3:0] -> ascending [0:3], MSB to MSB.
    assign w_asc = i_nib;

    // Ascending [0:3] -> descending [3:0], MSB to MSB.
    assign o_nib = w_asc;

endmodule : nib_slice

// File: rtl/slice_passthru.sv
// Slice/range-reversal pass-through. The o path is purely combinational and
// independent of clk/rst. o_q is a registered copy of i, and chg pulses for
// one cycle after o_q takes a new value. WIDTH must be a multiple of 4.
module slice_passthru
    import slice_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] o,
    input  logic [WIDTH-1:0] i,
    output logic [WIDTH-1:0] o_q,
    output logic             chg
);

    // Number of 4-bit slices; derived, not a parameter.
    localparam int NIB = WIDTH / NIB_W;

    logic [WIDTH-1:0] w_o;
    logic [WIDTH-1:0] r_o_q;
    logic             r_chg;

    // Split i into nibbles, route each through the range-conversion slice and
    // reassemble in the original slice order.
    for (genvar g = 0; g < NIB; g++) begin : g_nib
        nib_slice u_nib_slice (
            .i_nib (i[g*NIB_W +: NIB_W]),
            .o_nib (w_o[g*NIB_W +: NIB_W])
        );
    end

    assign o = w_o;

    // Register i and flag a change against the pre-edge registered value.
    // Case inequality so that an X arriving on i counts as a change.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_o_q <= '0;
            r_chg <= 1'b0;
        end else begin
            r_o_q <= i;
            r_chg <= (i !== r_o_q);
        end
    end

    assign o_q = r_o_q;
    assign chg = r_chg;

endmodule : slice_passthru

// File: tb/tb_slice_passthru.sv
// Bench for slice_passthru: combinational identity checks, a small reference
// model for o_q/chg feeding an expected queue, and a final report.
module tb_slice_passthru;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [W-1:0] o;
    logic [W-1:0] i;
    logic [W-1:0] o_q;
    logic         chg;

    int n_total = 0;
    int n_bad   = 0;

    // Expected {chg, o_q} after each edge.
    logic [W:0]   exp_q[$];
    // Model of the registered value before the coming edge.
    logic [W-1:0] m_q;

    slice_passthru #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .o   (o),
        .i   (i),
        .o_q (o_q),
        .chg (chg)
    );

    // Clock: 10 ns period, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", tag, act, exp);
        end
    endtask

    // Drive one cycle: apply v/r just after an edge, check o 1 ns later,
    // push the model's post-edge expectation, then pop and compare after the
    // next edge.
    task automatic drive_cycle(input logic [W-1:0] v, input logic r);
        logic [W-1:0] e_q;
        logic         e_chg;
        logic [W:0]   ent;
        i   = v;
        rst = r;
        #1;
        chk("o", o, v);
        if (r) begin
            e_q   = '0;
            e_chg = 1'b0;
        end else begin
            e_q   = v;
            e_chg = (v !== m_q);
        end
        m_q = e_q;
        exp_q.push_back({e_chg, e_q});
        @(posedge clk);
        #1;
        ent = exp_q.pop_front();
        chk("o_q", o_q, ent[W-1:0]);
        chk("chg", {{(W-1){1'b0}}, chg}, {{(W-1){1'b0}}, ent[W]});
    endtask

    initial begin
        logic [W-1:0] v;
        logic [W-1:0] xv;
        int           chg_cnt;
        int           r;

        i   = '0;
        rst = 1'b1;
        m_q = '0;
        @(posedge clk);
        #1;

        // Reset state.
        drive_cycle(8'h00, 1'b1);
        drive_cycle(8'h00, 1'b1);
        chk("rst_o_q", o_q, 8'h00);

        // Static value: first cycle after release, chg pulses once.
        drive_cycle(8'hA5, 1'b0);
        chk("a5_chg_hi", {7'd0, chg}, 8'h01);
        drive_cycle(8'hA5, 1'b0);
        chk("a5_chg_lo", {7'd0, chg}, 8'h00);
        chk("a5_o_q", o_q, 8'hA5);

        // Walking one, no bit reversal.
        for (int k = 0; k < W; k++) begin
            v = 8'h01 << k;
            drive_cycle(v, 1'b0);
        end
        chk("walk_80", o, 8'h80);

        // 4-state pattern passes through unresolved.
        xv = 8'b1x0x_10x1;
        drive_cycle(xv, 1'b0);
        chk("xpat_o", o, xv);

        // Reset mid-operation from 8'h3C.
        drive_cycle(8'h3C, 1'b0);
        chk("pre_rst_o_q", o_q, 8'h3C);
        drive_cycle(8'h3C, 1'b1);
        chk("mid_rst_o_q", o_q, 8'h00);
        chk("mid_rst_chg", {7'd0, chg}, 8'h00);
        chk("mid_rst_o", o, 8'h3C);

        // Hold 8'h5A for 5 cycles after reset: chg high exactly once.
        drive_cycle(8'h00, 1'b1);
        chg_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            drive_cycle(8'h5A, 1'b0);
            if (chg === 1'b1) chg_cnt++;
        end
        chk("hold_chg_cnt", chg_cnt[W-1:0], 8'd1);

        // Random 4-state vectors: 1 with p=6/16, X with p=2/16, else 0.
        for (int n = 0; n < 20000; n++) begin
            for (int b = 0; b < W; b++) begin
                r = $urandom_range(0, 15);
                if (r < 6)      v[b] = 1'b1;
                else if (r < 8) v[b] = 1'bx;
                else            v[b] = 1'b0;
            end
            drive_cycle(v, ($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_slice_passthru
